interfaz_dac_spi: RTL and testbench

- Output stage after the 200 Hz low-pass filter.
- Captures each filtered sample Yk when the filter raises Bandera_Listo.
- Saturates and rescales the sample to a 12-bit offset-binary DAC code.
- Transmits the code MSB-first as a 16-bit SPI frame to a serial DAC.
- Counterpart to the ADC capture path: the filter's consumer, closing the ADC → filter → DAC chain.

---
 rtl/interfaz_dac_spi.sv | 149 ++++++++++++++
 tb/tb_interfaz_dac_spi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interfaz_dac_spi.sv
// DAC output stage: captures filtered samples, converts them to 12-bit
// offset-binary codes and ships them as 16-bit MSB-first SPI frames.
module interfaz_dac_spi #(
    parameter int N       = 25,
    parameter int FRAC    = 16,
    parameter int CLK_DIV = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic signed [N-1:0] Yk,
    input  logic                Bandera_Listo,
    output logic                SCLK,
    output logic                SYNC_n,
    output logic                DIN,
    output logic                Ocupado,
    output logic                Dato_Perdido
);

    localparam int SH = FRAC - 11;
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
    // IDLE adds one cycle, so SYNC_n stays high 2*CLK_DIV cycles total
    localparam logic [CW-1:0] GAP_END = CW'(2 * CLK_DIV - 2);
    localparam logic signed [N-1:0] Y_MAX =
        {{(N - FRAC){1'b0}}, {FRAC{1'b1}}};
    localparam logic signed [N-1:0] Y_MIN =
        {{(N - FRAC){1'b1}}, {FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [4:0]     hp, hp_d;
    logic [15:0]    sr, sr_d;
    logic           sclk_d, sync_d;
    logic [11:0]    p, p_d;
    logic           pv, pv_d;
    logic           bl_q;
    logic           lost_d;
    logic           capture, start;

    logic signed [N-1:0] sat, shifted;
    logic [11:0]         code;
    logic                unused_hi;

    always_comb begin
        unique case (1'b1)
            (Yk > Y_MAX): sat = Y_MAX;
            (Yk < Y_MIN): sat = Y_MIN;
            default:      sat = Yk;
        endcase
    end

    // value is in [-2048, 2047]; adding 2048 flips the sign bit
    assign shifted   = sat >>> SH;
    assign code      = {~shifted[11], shifted[10:0]};
    assign unused_hi = ^shifted[N-1:12];

    assign capture = Bandera_Listo & ~bl_q;
    assign DIN     = sr[15];
    assign Ocupado = (state != IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hp_d    = hp;
        sr_d    = sr;
        sclk_d  = SCLK;
        sync_d  = SYNC_n;
        start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pv) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                    sr_d    = {4'b0000, p};
                    sync_d  = 1'b0;
                    sclk_d  = 1'b1;
                    cnt_d   = '0;
                    hp_d    = '0;
                end
            end
            SHIFT: begin
                if (cnt == HALF_END) begin
                    cnt_d = '0;
                    hp_d  = hp + 5'd1;
                    if (hp == 5'd31) begin
                        state_d = GAP;
                        sclk_d  = 1'b1;
                        sync_d  = 1'b1;
                        sr_d    = '0;
                    end else begin
                        sclk_d = ~SCLK;
                        if (!SCLK) sr_d = {sr[14:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pv_d   = pv;
        p_d    = p;
        lost_d = capture & pv & ~start;
        if (start) pv_d = 1'b0;
        if (capture) begin
            pv_d = 1'b1;
            p_d  = code;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hp           <= '0;
            sr           <= '0;
            SCLK         <= 1'b1;
            SYNC_n       <= 1'b1;
            p            <= '0;
            pv           <= 1'b0;
            bl_q         <= 1'b0;
            Dato_Perdido <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            hp           <= hp_d;
            sr           <= sr_d;
            SCLK         <= sclk_d;
            SYNC_n       <= sync_d;
            p            <= p_d;
            pv           <= pv_d;
            bl_q         <= Bandera_Listo;
            Dato_Perdido <= lost_d;
        end
    end

endmodule

// File: tb/tb_interfaz_dac_spi.sv
// Bench for interfaz_dac_spi: SPI frames decoded by a monitor and
// matched against a queue of expected codes.
module tb_interfaz_dac_spi;

    localparam int D = 4;

    logic               Clk;
    logic               Rst_n;
    logic signed [24:0] Yk;
    logic               Bandera_Listo;
    logic               SCLK, SYNC_n, DIN, Ocupado, Dato_Perdido;

    interfaz_dac_spi #(.N(25), .FRAC(16), .CLK_DIV(D)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Yk            (Yk),
        .Bandera_Listo (Bandera_Listo),
        .SCLK          (SCLK),
        .SYNC_n        (SYNC_n),
        .DIN           (DIN),
        .Ocupado       (Ocupado),
        .Dato_Perdido  (Dato_Perdido)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] sb[$];
    int          falls[$];
    int          frames  = 0;
    int          lost_hi = 0;
    int          ncyc    = 0;
    bit          in_frame = 0;
    int          low_len, nbits, din_bad;
    logic [15:0] shreg;
    logic        prev_sclk = 1'b1, prev_sync = 1'b1, prev_din = 1'b0;

    always @(negedge Clk) begin
        ncyc++;
        if (!Rst_n) begin
            in_frame  = 0;
            prev_sclk = 1'b1;
            prev_sync = 1'b1;
            prev_din  = 1'b0;
        end else begin
            if (Dato_Perdido) lost_hi++;
            if (prev_sync && !SYNC_n) begin
                in_frame = 1;
                low_len  = 0;
                nbits    = 0;
                din_bad  = 0;
                shreg    = '0;
                falls.push_back(ncyc);
            end
            if (!SYNC_n) begin
                low_len++;
                if (prev_sclk && !SCLK) begin
                    shreg = {shreg[14:0], DIN};
                    nbits++;
                end
                if (!prev_sync && DIN != prev_din && !(SCLK && !prev_sclk))
                    din_bad++;
            end
            if (!prev_sync && SYNC_n && in_frame) begin
                in_frame = 0;
                frames++;
                check("frame_bits", nbits, 16);
                check("sync_low_len", low_len, 32 * D);
                check("din_stable", din_bad, 0);
                if (sb.size() == 0) check("unexpected_frame", shreg, 32'hDEAD);
                else check("frame_data", shreg, sb.pop_front());
            end
            prev_sclk = SCLK;
            prev_sync = SYNC_n;
            prev_din  = DIN;
        end
    end

    task automatic pulse(input logic [24:0] v);
        @(negedge Clk);
        Yk = v;
        Bandera_Listo = 1'b1;
        @(negedge Clk);
        Bandera_Listo = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames < target && k < budget) begin
            @(negedge Clk);
            k++;
        end
        check("frame_timeout", 32'(frames >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (Ocupado && k < budget) begin
            @(negedge Clk);
            k++;
        end
        check("idle_timeout", Ocupado, 0);
        repeat (3) @(negedge Clk);
    endtask

    typedef struct {
        logic [24:0] yk;
        logic [11:0] code;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, l0, fs;
        vecs[0] = '{25'h0008000, 12'hC00};
        vecs[1] = '{25'h0010000, 12'hFFF};
        vecs[2] = '{25'h1FF0000, 12'h000};
        vecs[3] = '{25'h1FD0000, 12'h000};
        vecs[4] = '{25'h1FFFFFF, 12'h7FF};
        vecs[5] = '{25'h0FFFFFF, 12'hFFF};
        vecs[6] = '{25'h0000020, 12'h801};
        vecs[7] = '{25'h1FFFFDF, 12'h7FE};
        vecs[8] = '{25'h000FFFF, 12'hFFF};

        Rst_n = 1'b0;
        Yk = '0;
        Bandera_Listo = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_sclk", SCLK, 1);
        check("rst_sync", SYNC_n, 1);
        check("rst_din", DIN, 0);
        check("rst_busy", Ocupado, 0);
        check("rst_lost", Dato_Perdido, 0);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        // first frame with latency check
        sb.push_back(16'h0800);
        @(negedge Clk);
        Yk = '0;
        Bandera_Listo = 1'b1;
        @(negedge Clk);
        Bandera_Listo = 1'b0;
        check("lat_sync_k", SYNC_n, 1);
        @(negedge Clk);
        check("lat_sync_k1", SYNC_n, 0);
        check("lat_din_k1", DIN, 0);
        check("lat_busy_k1", Ocupado, 1);
        check("lat_sclk_k1", SCLK, 1);
        wait_frames(1, 400);
        wait_idle(100);

        foreach (vecs[i]) begin
            f0 = frames;
            sb.push_back({4'h0, vecs[i].code});
            pulse(vecs[i].yk);
            wait_frames(f0 + 1, 400);
            wait_idle(100);
        end

        // level held high: one rising edge only
        f0 = frames;
        sb.push_back(16'h0A00);
        @(negedge Clk);
        Yk = 25'h0004000;
        Bandera_Listo = 1'b1;
        repeat (300) @(negedge Clk);
        Bandera_Listo = 1'b0;
        repeat (200) @(negedge Clk);
        check("held_one_frame", frames - f0, 1);
        wait_idle(100);

        // three captures in one frame: latest wins
        f0 = frames;
        l0 = lost_hi;
        sb.push_back(16'h0900);
        sb.push_back(16'h0E00);
        pulse(25'h0002000);
        repeat (18) @(negedge Clk);
        pulse(25'h1FFE000);
        repeat (18) @(negedge Clk);
        pulse(25'h000C000);
        wait_frames(f0 + 2, 600);
        repeat (200) @(negedge Clk);
        check("three_frames", frames - f0, 2);
        check("three_lost", lost_hi - l0, 1);
        wait_idle(100);

        // capture coinciding with IDLE->SHIFT
        f0 = frames;
        l0 = lost_hi;
        sb.push_back(16'h0800);
        sb.push_back(16'h0C00);
        sb.push_back(16'h0FFF);
        pulse(25'h0000000);
        repeat (19) @(negedge Clk);
        pulse(25'h0008000);
        repeat (114) @(negedge Clk);
        pulse(25'h0010000);
        wait_frames(f0 + 3, 800);
        fs = falls.size();
        check("same_edge_lost", lost_hi - l0, 0);
        check("gap_1_2", falls[fs-2] - falls[fs-3], 136);
        check("gap_2_3", falls[fs-1] - falls[fs-2], 136);
        wait_idle(100);

        // reset in the middle of a frame
        f0 = frames;
        fs = falls.size();
        pulse(25'h0004000);
        repeat (41) @(negedge Clk);
        check("pre_rst_sync", SYNC_n, 0);
        #1;
        Rst_n = 1'b0;
        #1;
        check("arst_sclk", SCLK, 1);
        check("arst_sync", SYNC_n, 1);
        check("arst_din", DIN, 0);
        check("arst_busy", Ocupado, 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (300) @(negedge Clk);
        check("no_resume_frames", frames - f0, 0);
        check("no_resume_falls", falls.size() - fs, 1);
        sb.push_back(16'h0FFF);
        pulse(25'h0010000);
        wait_frames(f0 + 1, 400);
        wait_idle(100);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
